// File: rtl/hazard_scoreboard.sv
// Decode/execute hazard scoreboard: per-register latency countdown plus one
// variable-latency slot, producing stall/flush controls and a stall counter.
module hazard_scoreboard #(
    parameter int NREG   = 32,
    parameter int REG_AW = 5,
    parameter int LAT_W  = 3,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IssueD,
    input  logic              RegWriteD,
    input  logic [REG_AW-1:0] RdD,
    input  logic [LAT_W-1:0]  LatD,
    input  logic              VarLatD,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic              Rs1UsedD,
    input  logic              Rs2UsedD,
    input  logic              PCSrcE,
    input  logic              WbValid,
    input  logic [REG_AW-1:0] WbRd,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [NREG-1:0]   BusyVec,
    output logic              VarBusy,
    output logic              SbErr,
    output logic [CNT_W-1:0]  StallCnt
);

    logic [LAT_W-1:0]  cnt_q [NREG];
    logic [LAT_W-1:0]  cnt_d [NREG];
    logic [NREG-1:0]   var_pend_q, var_pend_d;
    logic              var_busy_q, var_busy_d;
    logic [REG_AW-1:0] var_rd_q, var_rd_d;
    logic              sb_err_q, sb_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [NREG-1:0] busy;
    logic raw, waw, strc, haz, issue;
    logic wb_hit, wb_miss;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy[r] = (cnt_q[r] != '0) | var_pend_q[r];
        end
        busy[0] = 1'b0;
    end

    always_comb begin
        raw  = (Rs1UsedD & (Rs1D != '0) & busy[Rs1D])
             | (Rs2UsedD & (Rs2D != '0) & busy[Rs2D]);
        waw  = IssueD & RegWriteD & (RdD != '0)
             & (var_pend_q[RdD] | (~VarLatD & (cnt_q[RdD] > LatD)));
        strc = IssueD & VarLatD & var_busy_q;
        haz  = IssueD & (raw | waw | strc);
        issue = IssueD & ~haz & ~PCSrcE;
    end

    assign StallF   = haz & ~PCSrcE;
    assign StallD   = haz & ~PCSrcE;
    assign FlushD   = PCSrcE;
    assign FlushE   = haz | PCSrcE;
    assign BusyVec  = busy;
    assign VarBusy  = var_busy_q;
    assign SbErr    = sb_err_q;
    assign StallCnt = stall_cnt_q;

    // A completion only clears the slot it matches; anything else is sticky error.
    assign wb_hit  = WbValid & var_busy_q & (WbRd == var_rd_q);
    assign wb_miss = WbValid & ~wb_hit;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : cnt_q[r];
        end
        var_pend_d  = var_pend_q;
        var_busy_d  = var_busy_q;
        var_rd_d    = var_rd_q;
        sb_err_d    = sb_err_q | wb_miss;
        stall_cnt_d = stall_cnt_q;

        if (issue & RegWriteD & (RdD != '0) & ~VarLatD) begin
            cnt_d[RdD] = LatD;
        end
        if (issue & VarLatD) begin
            var_busy_d = 1'b1;
            var_rd_d   = RdD;
            if (RdD != '0) begin
                var_pend_d[RdD] = 1'b1;
            end
        end
        if (wb_hit) begin
            var_busy_d           = 1'b0;
            var_pend_d[var_rd_q] = 1'b0;
        end
        if (StallD && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            var_pend_q  <= '0;
            var_busy_q  <= 1'b0;
            var_rd_q    <= '0;
            sb_err_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            var_pend_q  <= var_pend_d;
            var_busy_q  <= var_busy_d;
            var_rd_q    <= var_rd_d;
            sb_err_q    <= sb_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        IssueD = 1'b0, RegWriteD = 1'b0, VarLatD = 1'b0;
    logic [4:0]  RdD = '0, Rs1D = '0, Rs2D = '0, WbRd = '0;
    logic [2:0]  LatD = '0;
    logic        Rs1UsedD = 1'b0, Rs2UsedD = 1'b0;
    logic        PCSrcE = 1'b0, WbValid = 1'b0;
    logic        StallF, StallD, FlushD, FlushE, VarBusy, SbErr;
    logic [31:0] BusyVec;
    logic [31:0] StallCnt;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .IssueD(IssueD), .RegWriteD(RegWriteD),
        .RdD(RdD), .LatD(LatD), .VarLatD(VarLatD), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .Rs1UsedD(Rs1UsedD), .Rs2UsedD(Rs2UsedD), .PCSrcE(PCSrcE),
        .WbValid(WbValid), .WbRd(WbRd), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE), .BusyVec(BusyVec),
        .VarBusy(VarBusy), .SbErr(SbErr), .StallCnt(StallCnt)
    );

    always #5 clk = ~clk;

    int     nvec = 0;
    int     nerr = 0;
    bit     go = 1'b0;

    int     m_cnt [32];
    bit     m_vp  [32];
    bit     m_vb, m_err;
    int     m_vrd;
    longint m_sc;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_busy(int r);
        return (r != 0) && ((m_cnt[r] != 0) || m_vp[r]);
    endfunction

    function automatic bit m_haz();
        bit raw, waw, strc;
        raw  = (Rs1UsedD && m_busy(int'(Rs1D))) || (Rs2UsedD && m_busy(int'(Rs2D)));
        waw  = RegWriteD && (RdD != 0) &&
               (m_vp[RdD] || (!VarLatD && (m_cnt[RdD] > int'(LatD))));
        strc = VarLatD && m_vb;
        return IssueD && (raw || waw || strc);
    endfunction

    always @(posedge clk or posedge reset) begin
        bit hz, iss;
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                m_cnt[r] = 0;
                m_vp[r]  = 0;
            end
            m_vb = 0; m_err = 0; m_vrd = 0; m_sc = 0;
        end else begin
            hz  = m_haz();
            iss = IssueD && !hz && !PCSrcE;
            if (hz && !PCSrcE && m_sc < 64'hFFFF_FFFF) m_sc++;
            for (int r = 0; r < 32; r++) begin
                if (m_cnt[r] > 0) m_cnt[r]--;
            end
            if (WbValid) begin
                if (m_vb && int'(WbRd) == m_vrd) begin
                    m_vb = 0;
                    m_vp[m_vrd] = 0;
                end else begin
                    m_err = 1;
                end
            end
            if (iss && RegWriteD && RdD != 0 && !VarLatD) m_cnt[RdD] = int'(LatD);
            if (iss && VarLatD) begin
                m_vb  = 1;
                m_vrd = int'(RdD);
                if (RdD != 0) m_vp[RdD] = 1;
            end
        end
    end

    always @(negedge clk) begin
        bit hz;
        logic [31:0] bv;
        if (go) begin
            hz = m_haz();
            for (int r = 0; r < 32; r++) bv[r] = m_busy(r);
            check("StallF", 64'(StallF), 64'(hz && !PCSrcE));
            check("StallD", 64'(StallD), 64'(hz && !PCSrcE));
            check("FlushD", 64'(FlushD), 64'(PCSrcE));
            check("FlushE", 64'(FlushE), 64'(hz || PCSrcE));
            check("BusyVec", 64'(BusyVec), 64'(bv));
            check("VarBusy", 64'(VarBusy), 64'(m_vb));
            check("SbErr", 64'(SbErr), 64'(m_err));
            check("StallCnt", 64'(StallCnt), 64'(m_sc[31:0]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        IssueD = 0; RegWriteD = 0; VarLatD = 0; RdD = 0; LatD = 0;
        Rs1D = 0; Rs2D = 0; Rs1UsedD = 0; Rs2UsedD = 0;
        PCSrcE = 0; WbValid = 0; WbRd = 0;
    endtask

    task automatic prod(input int rd, input int lat, input bit var_op);
        idle();
        IssueD = 1; RegWriteD = 1; RdD = 5'(rd); LatD = 3'(lat); VarLatD = var_op;
    endtask

    initial begin
        #1 reset = 1;
        #1 go = 1;
        #19 reset = 0;
        cyc();
        mid();
        check("rst_StallCnt", 64'(StallCnt), 0);
        check("rst_BusyVec", 64'(BusyVec), 0);

        // producer x5 lat 1, dependent stalls exactly one cycle
        prod(5, 1, 0);
        mid(); check("s1_nostall", 64'(StallD), 0);
        cyc(); idle(); IssueD = 1; Rs1D = 5; Rs1UsedD = 1;
        mid(); check("s1_StallF", 64'(StallF), 1);
        check("s1_StallD", 64'(StallD), 1);
        check("s1_FlushE", 64'(FlushE), 1);
        cyc();
        mid(); check("s1_go", 64'(StallD), 0);
        check("s1_cnt", 64'(StallCnt), 1);

        // lat 0 never marks busy
        cyc(); prod(7, 0, 0);
        cyc(); idle(); IssueD = 1; Rs2D = 7; Rs2UsedD = 1;
        mid(); check("s2_stall", 64'(StallD), 0);
        check("s2_busy7", 64'(BusyVec[7]), 0);

        // variable-latency producer x10, completion visible next cycle
        cyc(); prod(10, 0, 1);
        cyc(); idle(); IssueD = 1; Rs1D = 10; Rs1UsedD = 1;
        mid(); check("s3_stall", 64'(StallD), 1);
        check("s3_vbusy", 64'(VarBusy), 1);
        cyc(); cyc(); cyc();
        WbValid = 1; WbRd = 10;
        mid(); check("s3_wb_stall", 64'(StallD), 1);
        cyc(); WbValid = 0;
        mid(); check("s3_release", 64'(StallD), 0);
        check("s3_vbusy0", 64'(VarBusy), 0);
        check("s3_err", 64'(SbErr), 0);

        // structural stall plus mismatched completion
        cyc(); prod(11, 0, 1);
        cyc(); prod(12, 0, 1); WbValid = 1; WbRd = 3;
        mid(); check("s4_strc", 64'(StallD), 1);
        cyc(); WbValid = 0;
        mid(); check("s4_err", 64'(SbErr), 1);
        check("s4_vbusy", 64'(VarBusy), 1);
        check("s4_still", 64'(StallD), 1);
        WbValid = 1; WbRd = 11;
        cyc(); WbValid = 0;
        mid(); check("s4_issue", 64'(StallD), 0);
        cyc(); idle(); WbValid = 1; WbRd = 12;
        cyc(); WbValid = 0;
        mid(); check("s4_vb0", 64'(VarBusy), 0);
        check("s4_sticky", 64'(SbErr), 1);

        // branch overrides a RAW stall; then WAW on x6
        cyc(); prod(6, 3, 0);
        cyc(); prod(9, 2, 0); Rs1D = 6; Rs1UsedD = 1; PCSrcE = 1;
        mid(); check("s5_StallF", 64'(StallF), 0);
        check("s5_StallD", 64'(StallD), 0);
        check("s5_FlushD", 64'(FlushD), 1);
        check("s5_FlushE", 64'(FlushE), 1);
        cyc(); prod(6, 1, 0);
        mid(); check("s5_busy9", 64'(BusyVec[9]), 0);
        check("s5_waw", 64'(StallD), 1);
        cyc();
        mid(); check("s5_waw_go", 64'(StallD), 0);

        // x0 never busy; reset mid-countdown clears all
        cyc(); prod(0, 7, 0);
        cyc(); idle();
        mid(); check("s6_x0", 64'(BusyVec), 0);
        cyc(); prod(4, 5, 0);
        cyc(); idle();
        mid(); check("s6_busy4", 64'(BusyVec[4]), 1);
        reset = 1;
        #1;
        check("s6_rst_busy", 64'(BusyVec), 0);
        check("s6_rst_cnt", 64'(StallCnt), 0);
        check("s6_rst_err", 64'(SbErr), 0);
        cyc(); reset = 0;

        for (int i = 0; i < 3000; i++) begin
            cyc();
            IssueD    = $urandom_range(0, 9) < 8;
            RegWriteD = $urandom_range(0, 9) < 8;
            VarLatD   = $urandom_range(0, 7) == 0;
            RdD       = 5'($urandom_range(0, 7));
            LatD      = 3'($urandom_range(0, 7));
            Rs1D      = 5'($urandom_range(0, 7));
            Rs2D      = 5'($urandom_range(0, 7));
            Rs1UsedD  = $urandom_range(0, 1);
            Rs2UsedD  = $urandom_range(0, 1);
            PCSrcE    = $urandom_range(0, 9) == 0;
            WbValid   = 0;
            WbRd      = 0;
            if (m_vb && $urandom_range(0, 4) == 0) begin
                WbValid = 1;
                WbRd    = 5'(m_vrd);
            end else if ($urandom_range(0, 199) == 0) begin
                WbValid = 1;
                WbRd    = 5'($urandom_range(0, 31));
            end
        end
        cyc(); idle();
        cyc(); cyc();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
